// File: rtl/ucb_arm_select_pkg.sv
// rtl/ucb_arm_select_pkg.sv - shared state encodings and fp32 field helpers for the arm selector
package ucb_arm_select_pkg;

  // Decision FSM; 2'd3 is unused and falls back to ST_COLLECT
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPARE = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // fp32 field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  // NaN: exponent all ones with a non-zero mantissa (infinities are not NaN)
  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/ucb_arm_select_fp32_cmp_gt.sv
// rtl/ucb_arm_select_fp32_cmp_gt.sv - combinational fp32 greater-than / equality compare
module fp32_cmp_gt
  import ucb_arm_select_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        eq,
  output logic        a_nan,
  output logic        b_nan
);

  logic        w_sa;
  logic        w_sb;
  logic [30:0] w_ma;
  logic [30:0] w_mb;
  logic        w_both_zero;

  assign w_sa        = a[SIGN_BIT];
  assign w_sb        = b[SIGN_BIT];
  assign w_ma        = a[EXP_MSB:0];
  assign w_mb        = b[EXP_MSB:0];
  assign a_nan       = fp32_is_nan(a);
  assign b_nan       = fp32_is_nan(b);
  // +0 and -0 are the same value regardless of sign
  assign w_both_zero = (w_ma == '0) && (w_mb == '0);

  // Sign-magnitude ordering; any NaN operand makes both a_gt_b and eq false
  always_comb begin
    a_gt_b = 1'b0;
    eq     = 1'b0;
    if (!(a_nan || b_nan)) begin
      if (w_both_zero) begin
        eq = 1'b1;
      end else if (w_sa == w_sb) begin
        eq     = (w_ma == w_mb);
        a_gt_b = w_sa ? (w_ma < w_mb) : (w_ma > w_mb);
      end else begin
        a_gt_b = !w_sa;
      end
    end
  end

endmodule

// File: rtl/ucb_arm_select.sv
// rtl/ucb_arm_select.sv - two-arm Q capture, fp32 compare and valid/ready decision with pull counters
module ucb_arm_select
  import ucb_arm_select_pkg::*;
#(
  parameter int   CNT_W   = 16,
  parameter logic TIE_ARM = 1'b0
) (
  input  logic             clk,
  input  logic             s_aresetn,
  input  logic [31:0]      Q1_t,
  input  logic             float_Q1_valid,
  input  logic [31:0]      Q2_t,
  input  logic             float_Q2_valid,
  output logic             sel_arm,
  output logic [31:0]      sel_q,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             nan_err,
  output logic             overrun,
  output logic [CNT_W-1:0] pulls_arm0,
  output logic [CNT_W-1:0] pulls_arm1,
  output logic [CNT_W-1:0] round_cnt
);

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_h1;
  logic [31:0] r_h2;
  logic        r_f1;
  logic        r_f2;
  logic [31:0] r_s1;
  logic [31:0] r_s2;

  logic        w_take;
  logic        w_accept;
  logic        w_gt;
  logic        w_eq;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_pick;

  // Snapshot happens only in COLLECT once both arms have fresh values
  assign w_take   = (r_state == ST_COLLECT) && r_f1 && r_f2;
  assign w_accept = (r_state == ST_PRESENT) && sel_valid && sel_ready;

  fp32_cmp_gt u_cmp (
    .a      (r_s1),
    .b      (r_s2),
    .a_gt_b (w_gt),
    .eq     (w_eq),
    .a_nan  (w_a_nan),
    .b_nan  (w_b_nan)
  );

  // NaN never wins; two NaNs or equal values fall back to TIE_ARM
  always_comb begin
    w_pick = TIE_ARM;
    if (w_a_nan && w_b_nan) begin
      w_pick = TIE_ARM;
    end else if (w_a_nan) begin
      w_pick = 1'b1;
    end else if (w_b_nan) begin
      w_pick = 1'b0;
    end else if (w_eq) begin
      w_pick = TIE_ARM;
    end else begin
      w_pick = !w_gt;
    end
  end

  // Hold registers, arrival flags, snapshot and overrun detection
  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_h1    <= '0;
      r_h2    <= '0;
      r_f1    <= 1'b0;
      r_f2    <= 1'b0;
      r_s1    <= '0;
      r_s2    <= '0;
      overrun <= 1'b0;
    end else begin
      if (float_Q1_valid) begin
        r_h1 <= Q1_t;
      end
      if (float_Q2_valid) begin
        r_h2 <= Q2_t;
      end
      if (w_take) begin
        r_s1 <= r_h1;
        r_s2 <= r_h2;
      end
      // A strobe in the snapshot cycle starts the next round rather than overwriting this one
      r_f1 <= float_Q1_valid | (r_f1 & ~w_take);
      r_f2 <= float_Q2_valid | (r_f2 & ~w_take);
      if ((float_Q1_valid && r_f1 && !w_take) || (float_Q2_valid && r_f2 && !w_take)) begin
        overrun <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = ST_COLLECT;
    case (r_state)
      ST_COLLECT: w_next_state = w_take ? ST_COMPARE : ST_COLLECT;
      ST_COMPARE: w_next_state = ST_PRESENT;
      ST_PRESENT: w_next_state = sel_ready ? ST_COLLECT : ST_PRESENT;
      default:    w_next_state = ST_COLLECT;
    endcase
  end

  // Decision outputs, sticky NaN flag and saturating pull counters
  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      sel_arm    <= 1'b0;
      sel_q      <= '0;
      sel_valid  <= 1'b0;
      nan_err    <= 1'b0;
      pulls_arm0 <= '0;
      pulls_arm1 <= '0;
      round_cnt  <= '0;
    end else begin
      if (r_state == ST_COMPARE) begin
        sel_arm   <= w_pick;
        sel_q     <= w_pick ? r_s2 : r_s1;
        sel_valid <= 1'b1;
        if (w_a_nan || w_b_nan) begin
          nan_err <= 1'b1;
        end
      end
      if (w_accept) begin
        sel_valid <= 1'b0;
        if (round_cnt != '1) begin
          round_cnt <= round_cnt + CNT_W'(1);
        end
        if (!sel_arm && (pulls_arm0 != '1)) begin
          pulls_arm0 <= pulls_arm0 + CNT_W'(1);
        end
        if (sel_arm && (pulls_arm1 != '1)) begin
          pulls_arm1 <= pulls_arm1 + CNT_W'(1);
        end
      end
    end
  end

endmodule
